// File: rtl/asyn_fifo_rd_upsizer_if.sv
// Bus bundle for asyn_fifo_rd_upsizer.
// FIFO side : fifo_valid/fifo_data in, fifo_en out (FWFT pop strobe).
// Out side  : o_valid/o_data/o_keep out, o_ready in.
// master = the upsizer, slave = the FIFO plus downstream consumer.
interface asyn_fifo_rd_upsizer_if #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned RATIO     = 4
);
  logic                          fifo_valid;
  logic [DATAWIDTH-1:0]          fifo_data;
  logic                          fifo_en;
  logic                          o_valid;
  logic                          o_ready;
  logic [DATAWIDTH*RATIO-1:0]    o_data;
  logic [RATIO-1:0]              o_keep;

  modport master (
    input  fifo_valid, fifo_data, o_ready,
    output fifo_en, o_valid, o_data, o_keep
  );

  modport slave (
    output fifo_valid, fifo_data, o_ready,
    input  fifo_en, o_valid, o_data, o_keep
  );
endinterface

// File: rtl/asyn_fifo_rd_upsizer.sv
// Read-side width upsizer for the async FIFO wrapper (r_clk domain).
// Pops FWFT entries of DATAWIDTH bits and packs RATIO of them, LSB lane first, into one
// wide word presented on a valid/ready port.
//
// Ports:
//   r_clk  : sole clock (FIFO read clock)
//   r_rst  : synchronous active-high reset
//   up_io  : asyn_fifo_rd_upsizer_if.master
//            fifo_valid/fifo_data in, fifo_en out (combinational pop strobe)
//            o_valid/o_data/o_keep out, o_ready in
//
// Optional feature: define FLUSH_TIMEOUT_EN to flush a partially filled word after
// TIMEOUT idle cycles with o_keep marking the filled lanes. Without it, words leave only
// when full and o_keep is all ones whenever o_valid is high.
module asyn_fifo_rd_upsizer #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned RATIO     = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input logic                    r_clk,
  input logic                    r_rst,
  asyn_fifo_rd_upsizer_if.master up_io
);

  localparam int unsigned      CntW   = $clog2(RATIO);
  localparam logic [CntW-1:0]  CntMax = CntW'(RATIO - 1);

  if (RATIO < 2 || TIMEOUT < 1) begin : g_param_check
    $error("asyn_fifo_rd_upsizer: RATIO must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [RATIO-1:0]      keep_q;
  logic [DATAWIDTH-1:0]  lane_q [RATIO];

  logic                       pop;
  logic                       flush;
  logic [RATIO-1:0]           part_keep;
  logic [DATAWIDTH*RATIO-1:0] data_packed;

`ifdef FLUSH_TIMEOUT_EN
  localparam int unsigned      IdleW   = $clog2(TIMEOUT + 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT);

  logic [IdleW-1:0] idle_q;

  // Partial flush takes priority over a pop in the same cycle.
  assign flush = (state_q == StFill) && (cnt_q != '0) && (idle_q == IdleMax);
`else
  assign flush = 1'b0;
`endif

  // Pop strobe: never without fifo_valid, never during reset.
  always_comb begin
    pop = 1'b0;
    if (!r_rst) begin
      unique case (state_q)
        StFill:  pop = up_io.fifo_valid && !flush;
        StHold:  pop = up_io.fifo_valid && up_io.o_ready;
        default: pop = 1'b0;
      endcase
    end
  end

  // Lanes below the current fill count, used as the keep mask of a partial flush.
  always_comb begin
    part_keep = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      part_keep[k] = (CntW'(k) < cnt_q);
    end
  end

  always_comb begin
    data_packed = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      data_packed[k*DATAWIDTH +: DATAWIDTH] = lane_q[k];
    end
  end

  assign up_io.fifo_en = pop;
  assign up_io.o_valid = (state_q == StHold);
  assign up_io.o_data  = data_packed;
  assign up_io.o_keep  = keep_q;

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state_q <= StFill;
      cnt_q   <= '0;
      keep_q  <= '0;
      for (int unsigned k = 0; k < RATIO; k++) begin
        lane_q[k] <= '0;
      end
`ifdef FLUSH_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        StFill: begin
          if (pop) begin
            lane_q[cnt_q] <= up_io.fifo_data;
            if (cnt_q == CntMax) begin
              state_q <= StHold;
              keep_q  <= '1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end else if (flush) begin
            state_q <= StHold;
            keep_q  <= part_keep;
            cnt_q   <= '0;
          end
        end
        StHold: begin
          if (up_io.o_ready) begin
            state_q <= StFill;
            keep_q  <= '0;
            // Clear every lane so unfilled lanes of the next word read as zero; a
            // same-cycle pop then overrides lane 0.
            for (int unsigned k = 0; k < RATIO; k++) begin
              lane_q[k] <= '0;
            end
            if (pop) begin
              lane_q[0] <= up_io.fifo_data;
              cnt_q     <= CntW'(1);
            end else begin
              cnt_q <= '0;
            end
          end
        end
        default: state_q <= StFill;
      endcase
`ifdef FLUSH_TIMEOUT_EN
      // Count only while a partial word waits; any pop, flush or empty word clears it.
      if ((state_q == StFill) && (cnt_q != '0) && !pop && !flush) begin
        idle_q <= idle_q + IdleW'(1);
      end else begin
        idle_q <= '0;
      end
`endif
    end
  end

endmodule

// File: doc/asyn_fifo_rd_upsizer.md
# asyn_fifo_rd_upsizer

Read-side width upsizer that sits directly downstream of the async FIFO wrapper in the `r_clk` domain. It pops first-word-fall-through (FWFT) entries of DATAWIDTH bits and packs RATIO consecutive entries into one wide word, LSB lane first. It presents each wide word on a valid/ready output port. An optional idle timeout flushes partially filled words with a lane-keep mask.

## Interface
- DATAWIDTH, 8: width of one FIFO entry (lane).
- RATIO, 4: lanes per output word, ≥2.
- TIMEOUT, 16: idle cycles before a partial flush, ≥1. Used only when FLUSH_TIMEOUT_EN is defined.
- r_clk  in  1  sole clock; same clock as the FIFO read side.
- r_rst  in  1  synchronous, active-high reset.
- fifo_valid  in  1  FIFO head entry valid (FWFT `r_valid`).
- fifo_data  in  DATAWIDTH  FIFO head entry (`r_data`).
- fifo_en  out  1  pop strobe to the FIFO (`r_en`). Combinational. Only ever asserted together with fifo_valid.
- o_valid  out  1  output word valid.
- o_ready  in  1  downstream accepts the word.
- o_data  out  DATAWIDTH*RATIO  packed word; lane k is bits [k*DATAWIDTH +: DATAWIDTH].
- o_keep  out  RATIO  per-lane valid mask for the word on o_data.

## Operation
- Internal state: lane register array, fill count `cnt` (0..RATIO-1), idle counter `idle` of width clog2(TIMEOUT+1).
- There are two states, FILL and HOLD.
- FILL:
  - fifo_en = fifo_valid.
  - On a pop, lane[cnt] <= fifo_data, and idle is cleared.
  - If cnt == RATIO-1: go to HOLD with o_keep <= all ones and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
- HOLD:
  - o_valid = 1, and o_data/o_keep are stable until accepted.
  - If o_ready = 0: fifo_en = 0 and the state stalls.
  - If o_ready = 1 and fifo_valid = 1: the word is accepted and a pop happens in the same cycle. lane0 <= fifo_data, other lanes <= 0, cnt <= 1, state FILL. If RATIO were 1 this would not apply; RATIO ≥ 2 is required.
  - If o_ready = 1 and fifo_valid = 0: lanes <= 0, cnt <= 0, state FILL.
- Unfilled lanes always read as zero on o_data.
- o_keep outside HOLD is 0.
- A pop never occurs without fifo_valid. The FIFO side never sees fifo_en while it is empty.

## Timing
- Reset (r_rst high on a clock edge):
  - state FILL, cnt 0, idle 0, lanes 0.
  - o_valid 0, o_data 0, o_keep 0.
  - fifo_en is forced 0 while r_rst is high.
- Latency: the pop of the last lane at edge t gives o_valid = 1 after edge t, i.e. one cycle after the last pop.
- Throughput: one word per RATIO cycles with a continuously valid FIFO and o_ready held high, i.e. 100 % of FIFO bandwidth.
- Backpressure: o_valid, once high, stays high with stable o_data/o_keep until a cycle with o_ready = 1.
- Reset mid-word: any partially packed lanes are discarded, with no flush.
- Reset while HOLD: the word is dropped, and o_valid goes 0 after the edge.
- Simultaneous accept and pop in HOLD is required; no bubble is allowed.

## Configuration
- Macro FLUSH_TIMEOUT_EN.
- Defined:
  - In FILL with cnt > 0, idle increments on every cycle without a pop.
  - When idle reaches TIMEOUT, there is no pop that cycle. The state goes to HOLD with o_keep = lanes 0..cnt-1 set, then cnt <= 0 and idle <= 0.
  - idle is held at 0 while cnt == 0.
- Undefined:
  - No idle counter is built, and words are emitted only when full.
  - o_keep is all ones whenever o_valid = 1.

## Test plan
- Reset, then fifo_valid = 0 for 10 cycles: o_valid = 0, o_data = 0, o_keep = 0, fifo_en = 0 throughout.
- DATAWIDTH=8, RATIO=4, o_ready = 1. Stream 0x11,0x22,0x33,0x44,0x55… continuously: o_data = 0x44332211 with o_keep = 0xF one cycle after the 4th pop, then 0x88776655 exactly 4 cycles later. fifo_en stays high every cycle.
- Full word in HOLD with o_ready = 0 for 5 cycles while fifo_valid = 1: fifo_en = 0 and o_data is stable. When o_ready rises, the accept and pop of the next byte occur in the same cycle.
- FLUSH_TIMEOUT_EN, TIMEOUT=16. Push 0xAA,0xBB, then go idle: o_valid rises 16 idle cycles after the 2nd pop with o_data = 0x0000BBAA, o_keep = 0x3. Without the macro, o_valid stays 0 indefinitely.
- Assert r_rst for 1 cycle after 3 lanes are filled, then stream 4 bytes 0x01..0x04: the first output word is 0x04030201 with o_keep = 0xF, and no stale lanes appear.
